// File: rtl/holy_core_pkg.sv
// Shared types and constants for the Holy Core memory-side AXI responder.
package holy_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    W_DATA,
    W_RESP,
    R_DATA
  } axi_slave_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

  // Only full-word INCR bursts are supported; anything else completes with SLVERR.
  function automatic logic axi_fmt_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != AXI_SIZE_4B) || (burst != AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 channel bundle (32-bit data, no IDs) between the cache master and memory.
interface axi_if;

  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/holy_mem_array.sv
// Word-addressed RAM: one synchronous byte-enabled write port, one asynchronous read port.
module holy_mem_array #(
  parameter int    MEM_WORDS = 4096,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/holy_axi_mem_slave.sv
// AXI4 memory responder for the Holy Core caches: one INCR burst of 32-bit words at a time.
module holy_axi_mem_slave
  import holy_core_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter string       INIT_FILE = ""
) (
  input logic  aclk,
  input logic  aresetn,
  axi_if.slave axi
);

  localparam int          AW          = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  axi_slave_state_t state;
  logic             ready_en;
  logic [31:0]      ptr;
  logic [7:0]       beat_cnt;
  logic [7:0]       len;
  logic             err;

  logic        in_range;
  logic        last_beat;
  logic        aw_hs;
  logic        ar_hs;
  logic        w_hs;
  logic        r_hs;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign in_range  = ptr < MEM_WORDS_W;
  assign last_beat = beat_cnt == len;

  // Readies are held off for one cycle after reset release via ready_en.
  assign axi.awready = ready_en && (state == IDLE);
  assign axi.arready = ready_en && (state == IDLE) && !axi.awvalid;
  assign axi.wready  = state == W_DATA;
  assign axi.bvalid  = state == W_RESP;
  assign axi.rvalid  = state == R_DATA;

  assign axi.bresp = (state == W_RESP && err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi.rdata = (state == R_DATA && in_range) ? mem_rdata : 32'h0;
  assign axi.rresp = (state == R_DATA && (err || !in_range)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi.rlast = (state == R_DATA) && last_beat;

  assign aw_hs  = axi.awvalid && axi.awready;
  assign ar_hs  = axi.arvalid && axi.arready;
  assign w_hs   = axi.wvalid && axi.wready;
  assign r_hs   = axi.rvalid && axi.rready;
  assign mem_we = w_hs && in_range && !err;

  holy_mem_array #(
    .MEM_WORDS(MEM_WORDS),
    .INIT_FILE(INIT_FILE)
  ) u_mem (
    .clk  (aclk),
    .we   (mem_we),
    .waddr(ptr[AW-1:0]),
    .wstrb(axi.wstrb),
    .wdata(axi.wdata),
    .raddr(ptr[AW-1:0]),
    .rdata(mem_rdata)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      ready_en <= 1'b0;
      ptr      <= '0;
      beat_cnt <= '0;
      len      <= '0;
      err      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            ptr      <= (axi.awaddr - BASE_ADDR) >> 2;
            beat_cnt <= '0;
            len      <= axi.awlen;
            err      <= axi_fmt_err(axi.awsize, axi.awburst);
            state    <= W_DATA;
          end else if (ar_hs) begin
            ptr      <= (axi.araddr - BASE_ADDR) >> 2;
            beat_cnt <= '0;
            len      <= axi.arlen;
            err      <= axi_fmt_err(axi.arsize, axi.arburst);
            state    <= R_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            ptr      <= ptr + 32'd1;
            beat_cnt <= beat_cnt + 8'd1;
            // wlast disagreeing with awlen is flagged, but wlast alone ends the burst.
            if (!in_range || (axi.wlast != last_beat)) err <= 1'b1;
            if (axi.wlast) state <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi.bready) state <= IDLE;
        end
        R_DATA: begin
          if (r_hs) begin
            ptr      <= ptr + 32'd1;
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_holy_axi_mem_slave.sv
// Directed scoreboard bench for holy_axi_mem_slave: expected B/R responses are queued at issue time.
module tb_holy_axi_mem_slave;

  localparam int MW = 1024;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  axi_if axi_bus ();

  holy_axi_mem_slave #(
    .MEM_WORDS(MW),
    .BASE_ADDR(32'h0),
    .INIT_FILE("")
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .axi    (axi_bus)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model [MW];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no response expected handshake at %0t", name, $time);
  endtask

  // Monitor: compares every presented B / R beat against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (axi_bus.bvalid) begin
          if (sb.size() == 0 || sb[0].is_read) fail("b_unexpected");
          else begin
            chk32("bresp", 32'(axi_bus.bresp), 32'(sb[0].resp));
            if (axi_bus.bready) sb.delete(0);
          end
        end
        if (axi_bus.rvalid) begin
          if (sb.size() == 0 || !sb[0].is_read) fail("r_unexpected");
          else begin
            chk32("rdata", axi_bus.rdata, sb[0].data);
            chk32("rresp_rlast", 32'({axi_bus.rresp, axi_bus.rlast}), 32'({sb[0].resp, sb[0].last}));
            if (axi_bus.rready) sb.delete(0);
          end
        end
      end
    end
  end

  task automatic write_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [31:0] d0, input bit inc,
                             input logic [3:0] strb, input bit with_ar);
    logic [31:0] p;
    logic [31:0] d;
    bit          e;
    int          cyc;
    e = (size != 3'b010) || (burst != 2'b01);
    p = addr >> 2;
    for (int i = 0; i <= len; i++) begin
      d = inc ? d0 + 32'(i) : d0;
      if (p < MW && !e)
        for (int b = 0; b < 4; b++) if (strb[b]) model[p[9:0]][8*b +: 8] = d[8*b +: 8];
      if (p >= MW) e = 1'b1;
      p = p + 32'd1;
    end
    sb.push_back('{1'b0, 32'h0, e ? 2'b10 : 2'b00, 1'b0});

    @(posedge aclk); #1;
    axi_bus.awaddr  = addr;
    axi_bus.awlen   = 8'(len);
    axi_bus.awsize  = size;
    axi_bus.awburst = burst;
    axi_bus.awvalid = 1'b1;
    if (with_ar) begin
      axi_bus.araddr  = addr;
      axi_bus.arlen   = 8'(len);
      axi_bus.arsize  = 3'b010;
      axi_bus.arburst = 2'b01;
      axi_bus.arvalid = 1'b1;
    end
    cyc = 0;
    @(negedge aclk);
    while (!axi_bus.awready && cyc < 50) begin @(negedge aclk); cyc++; end
    if (!axi_bus.awready) begin fail("aw_timeout"); return; end
    if (axi_bus.arvalid) chk1("aw_wins_arready", axi_bus.arready, 1'b0);
    @(posedge aclk); #1;
    axi_bus.awvalid = 1'b0;
    axi_bus.wvalid  = 1'b1;
    axi_bus.wdata   = d0;
    axi_bus.wstrb   = strb;
    axi_bus.wlast   = (len == 0);

    for (int i = 0; i <= len; i++) begin
      cyc = 0;
      @(negedge aclk);
      if (i == 0) chk1("wready_latency", axi_bus.wready, 1'b1);
      while (!axi_bus.wready && cyc < 50) begin @(negedge aclk); cyc++; end
      if (!axi_bus.wready) begin fail("w_timeout"); axi_bus.wvalid = 1'b0; return; end
      @(posedge aclk); #1;
      if (i < len) begin
        axi_bus.wdata = inc ? d0 + 32'(i + 1) : d0;
        axi_bus.wlast = (i + 1 == len);
      end else begin
        axi_bus.wvalid = 1'b0;
        axi_bus.wlast  = 1'b0;
      end
    end

    @(negedge aclk);
    chk1("b_latency", axi_bus.bvalid, 1'b1);
    if (axi_bus.arvalid) chk1("ar_blocked_in_wresp", axi_bus.arready, 1'b0);
    cyc = 0;
    while (!axi_bus.bvalid && cyc < 50) begin @(negedge aclk); cyc++; end
    @(posedge aclk); #1;
  endtask

  task automatic read_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input bit stall, input int abort_at,
                            input bit use_exp0, input logic [31:0] exp0);
    logic [31:0] p;
    logic [31:0] d;
    bit          e;
    int          cyc;
    int          acc;
    e = (size != 3'b010) || (burst != 2'b01);
    p = addr >> 2;
    for (int i = 0; i <= len; i++) begin
      d = (p < MW) ? model[p[9:0]] : 32'h0;
      if (i == 0 && use_exp0) d = exp0;
      sb.push_back('{1'b1, d, (e || p >= MW) ? 2'b10 : 2'b00, (i == len)});
      p = p + 32'd1;
    end

    if (!axi_bus.arvalid) begin @(posedge aclk); #1; end
    axi_bus.araddr  = addr;
    axi_bus.arlen   = 8'(len);
    axi_bus.arsize  = size;
    axi_bus.arburst = burst;
    axi_bus.arvalid = 1'b1;
    cyc = 0;
    @(negedge aclk);
    while (!axi_bus.arready && cyc < 50) begin @(negedge aclk); cyc++; end
    if (!axi_bus.arready) begin fail("ar_timeout"); axi_bus.arvalid = 1'b0; return; end
    @(posedge aclk); #1;
    axi_bus.arvalid = 1'b0;
    axi_bus.rready  = !stall;

    acc = 0;
    cyc = 0;
    while (acc <= len && cyc < 4 * (len + 1) + 20) begin
      @(negedge aclk);
      if (cyc == 0) chk1("r_latency", axi_bus.rvalid, 1'b1);
      if (abort_at >= 0 && axi_bus.rvalid && acc == abort_at) begin
        #2;
        aresetn = 1'b0;
        #1;
        chk1("rst_rvalid_drop", axi_bus.rvalid, 1'b0);
        chk32("rst_rdata_zero", axi_bus.rdata, 32'h0);
        sb.delete();
        axi_bus.rready = 1'b0;
        @(posedge aclk);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk1("ready_held_after_rst", axi_bus.awready, 1'b0);
        @(negedge aclk);
        chk1("idle_after_rst", axi_bus.awready, 1'b1);
        return;
      end
      if (axi_bus.rvalid && axi_bus.rready) acc++;
      @(posedge aclk); #1;
      cyc++;
      axi_bus.rready = stall ? !axi_bus.rready : 1'b1;
    end
    axi_bus.rready = 1'b0;
    chk32("r_beat_count", 32'(acc), 32'(len + 1));
    @(negedge aclk);
    chk1("r_done_idle", axi_bus.rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within cycle budget");
    $fatal(1);
  end

  initial begin
    axi_bus.awaddr  = '0;
    axi_bus.awlen   = '0;
    axi_bus.awsize  = 3'b010;
    axi_bus.awburst = 2'b01;
    axi_bus.awvalid = 1'b0;
    axi_bus.wdata   = '0;
    axi_bus.wstrb   = '0;
    axi_bus.wlast   = 1'b0;
    axi_bus.wvalid  = 1'b0;
    axi_bus.bready  = 1'b1;
    axi_bus.araddr  = '0;
    axi_bus.arlen   = '0;
    axi_bus.arsize  = 3'b010;
    axi_bus.arburst = 2'b01;
    axi_bus.arvalid = 1'b0;
    axi_bus.rready  = 1'b0;

    // Reset state and the one-cycle ready hold-off after release.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk32("reset_ctrl_outputs", 32'({axi_bus.awready, axi_bus.arready, axi_bus.wready, axi_bus.bvalid,
                                     axi_bus.rvalid, axi_bus.rlast, axi_bus.bresp, axi_bus.rresp}), 32'h0);
    chk32("reset_rdata", axi_bus.rdata, 32'h0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk1("ready_held_first_cycle", axi_bus.awready, 1'b0);
    @(negedge aclk);
    chk1("awready_idle", axi_bus.awready, 1'b1);
    chk1("arready_idle", axi_bus.arready, 1'b1);

    // 128-beat write of i, then read it back.
    write_burst(32'h200, 127, 3'b010, 2'b01, 32'h0, 1'b1, 4'hF, 1'b0);
    read_burst(32'h200, 127, 3'b010, 2'b01, 1'b0, -1, 1'b1, 32'h0);

    // Byte strobes.
    write_burst(32'h100, 0, 3'b010, 2'b01, 32'h11223344, 1'b0, 4'hF, 1'b0);
    write_burst(32'h100, 0, 3'b010, 2'b01, 32'hAABBCCDD, 1'b0, 4'b0011, 1'b0);
    read_burst(32'h100, 0, 3'b010, 2'b01, 1'b0, -1, 1'b1, 32'h1122CCDD);

    // Simultaneous AW/AR: write first, read sees the new data.
    write_burst(32'h300, 3, 3'b010, 2'b01, 32'h5A5A0000, 1'b1, 4'hF, 1'b1);
    read_burst(32'h300, 3, 3'b010, 2'b01, 1'b0, -1, 1'b1, 32'h5A5A0000);

    // rready toggling on a long read.
    read_burst(32'h200, 127, 3'b010, 2'b01, 1'b1, -1, 1'b0, 32'h0);

    // Error paths.
    write_burst(32'h0, 0, 3'b010, 2'b01, 32'hCAFE0000, 1'b0, 4'hF, 1'b0);
    write_burst(32'(MW * 4), 0, 3'b010, 2'b01, 32'hDEADBEEF, 1'b0, 4'hF, 1'b0);
    read_burst(32'h0, 0, 3'b010, 2'b01, 1'b0, -1, 1'b1, 32'hCAFE0000);
    write_burst(32'((MW - 2) * 4), 3, 3'b010, 2'b01, 32'h77770000, 1'b1, 4'hF, 1'b0);
    read_burst(32'((MW - 2) * 4), 3, 3'b010, 2'b01, 1'b0, -1, 1'b1, 32'h77770000);
    write_burst(32'h100, 0, 3'b001, 2'b01, 32'hFFFFFFFF, 1'b0, 4'hF, 1'b0);
    read_burst(32'h100, 0, 3'b010, 2'b01, 1'b0, -1, 1'b1, 32'h1122CCDD);
    read_burst(32'h200, 3, 3'b001, 2'b01, 1'b0, -1, 1'b1, 32'h0);

    // Reset during beat 40 of a read, then a clean re-read.
    read_burst(32'h200, 127, 3'b010, 2'b01, 1'b0, 40, 1'b0, 32'h0);
    read_burst(32'h200, 127, 3'b010, 2'b01, 1'b0, -1, 1'b1, 32'h0);

    repeat (2) @(posedge aclk);
    chk32("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
